vpifo_req_sched: RTL and testbench
==================================

Name: vpifo_req_sched

Overview:
- Request scheduler in front of the per-tree push/pop lanes of the SRAM vPIFO top.
- Takes NREQ independent requesters, each with a valid/ready push-or-pop request targeting a tree.
- Round-robin arbitrates per tree and drives at most one operation per tree lane per cycle.
- Honours task-FIFO backpressure and per-tree occupancy, and routes pop results back to the issuing requester after a fixed latency.

Parameters:
- NREQ, 4: number of requesters.
- LEVEL, 4: number of trees / lanes.
- PTW, 8: push/pop data width.
- TIDW, 2: tree id width; $clog2(LEVEL).
- DEPTH, 16: per-tree element capacity tracked by the occupancy counter.
- POP_LAT, 2: cycles from lane pop strobe to valid pop data at the vPIFO output.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_req_valid  in  NREQ  request valid per requester
- o_req_ready  out  NREQ  request accepted this cycle
- i_req_op  in  NREQ  1=push, 0=pop
- i_req_tid  in  NREQ x TIDW  target tree
- i_req_data  in  NREQ x PTW  push data (ignored for pop)
- o_push  out  LEVEL  lane push strobe
- o_pop  out  LEVEL  lane pop strobe
- o_push_data  out  LEVEL x PTW  lane push data
- o_tree_id  out  LEVEL x TIDW  lane tree id (constant = lane index when idle)
- i_task_fifo_full  in  LEVEL  lane backpressure
- i_pop_data  in  LEVEL x PTW  lane pop result, valid POP_LAT cycles after o_pop
- o_rsp_valid  out  NREQ  pop response valid
- o_rsp_data  out  NREQ x PTW  pop response data
- o_occ  out  LEVEL x ($clog2(DEPTH)+1)  per-tree occupancy

Behaviour:
- Clocking and reset: single clock i_clk. Reset i_rst is synchronous, active-high.
- Reset values:
  - o_req_ready, o_push, o_pop, o_rsp_valid = 0; o_push_data, o_rsp_data = 0.
  - o_tree_id[l] = l; o_occ = 0.
  - RR pointers = 0; tag pipeline cleared.
- Eligibility of requester r for tree t = i_req_tid[r]:
  - push: requires occ[t] < DEPTH and !i_task_fifo_full[t].
  - pop: requires occ[t] > 0.
  - Ineligible requests stay pending: ready low, no drop.
- Arbitration:
  - One RR arbiter per tree over eligible requesters. At most one grant per tree per cycle; each requester is granted at most once.
  - The RR pointer advances to winner+1 only on grant.
- Issue timing (1-cycle registered):
  - Grant in cycle N sets o_req_ready[r] combinationally in N; the handshake completes in N.
  - o_push/o_pop[t], o_push_data[t] and o_tree_id[t] are registered and asserted in N+1 for exactly one cycle.
- Occupancy:
  - Updated at issue: push +1, pop -1.
  - Never exceeds DEPTH and never wraps below 0; eligibility guarantees this.
  - Full → empty → full sequences are counted exactly.
- Response routing:
  - Per lane, a POP_LAT-deep shift register carries {valid, requester index}, loaded when o_pop[t] asserts.
  - At the tail, o_rsp_valid[r] = 1 and o_rsp_data[r] = i_pop_data[t] for one cycle.
  - No collision is possible: one grant per requester per cycle plus fixed latency.
- Simultaneous events:
  - Push and pop requests to the same tree in the same cycle compete in the same RR. Only the winner issues.
  - i_task_fifo_full rising in the grant cycle blocks push grants in that cycle; pops remain eligible.
- Reset mid-operation: in-flight tags are discarded, and a pop response due after reset is never delivered. Occupancy returns to 0.
- Requester values must hold stable while valid && !ready. This is not checked in RTL.

Optional Feature:
- Macro: VPIFO_SCHED_STATS_EN.
- Defined:
  - Per-tree 32-bit counters for pushes issued, pops issued, and cycles with a pending-but-blocked request.
  - Exposed on output o_stats (LEVEL x 3 x 32).
  - Cleared by i_rst; saturate at all-ones.
- Undefined: the o_stats port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package vpifo_sched_pkg:
  - op enum (OP_POP=0, OP_PUSH=1).
  - req_t struct {op, tid, data}.
  - tag_t struct {valid, req_idx}.
  - Default width localparams.
- Sub-module vpifo_rr_arb: parameterised NREQ round-robin arbiter (req vector in, one-hot grant out, pointer update on grant). Instantiated LEVEL times.

Test Plan:
- Reset, then requesters 0..3 push 8'h01/11/21/31 to trees 0..3 together → all ready in the same cycle. o_push=4'hF for one cycle next cycle, o_push_data as given; o_occ=1 each.
- Requester 2 pops tree 2 after the above → o_pop=4'b0100 one cycle later; the bench drives pop data 8'h21 POP_LAT cycles later. Then o_rsp_valid=4'b0100 with o_rsp_data[2]=8'h21.
- All 4 requesters push to tree 0 continuously → grants in order 0,1,2,3,0 (one per cycle); o_occ[0] stops at DEPTH=16 and ready stays low afterwards.
- Pop on an empty tree 1 → ready stays low. A push from another requester to tree 1 then issues, and the pop is granted on a subsequent cycle with a response.
- i_task_fifo_full[3]=1 with pending push and pop on tree 3 (occ=2) → only the pop issues. The push issues the cycle after full drops.
- Assert i_rst one cycle after o_pop → no o_rsp_valid ever for that pop; all outputs and o_occ return to reset values.

Source files
------------

// File: rtl/vpifo_sched_pkg.sv
// vpifo_sched_pkg: shared types and default widths for the vPIFO request scheduler.
// Holds the op encoding, request/tag bundles and stats slot indices.
package vpifo_sched_pkg;

    localparam int NREQ_DEF    = 4;
    localparam int LEVEL_DEF   = 4;
    localparam int PTW_DEF     = 8;
    localparam int TIDW_DEF    = 2;
    localparam int DEPTH_DEF   = 16;
    localparam int POP_LAT_DEF = 2;
    localparam int RIDW_DEF    = $clog2(NREQ_DEF);

    // Slot order inside each tree's o_stats entry.
    localparam int STAT_PUSH  = 0;
    localparam int STAT_POP   = 1;
    localparam int STAT_BLOCK = 2;

    typedef enum logic {
        OP_POP  = 1'b0,
        OP_PUSH = 1'b1
    } op_e;

    typedef struct packed {
        op_e                 op;
        logic [TIDW_DEF-1:0] tid;
        logic [PTW_DEF-1:0]  data;
    } req_t;

    typedef struct packed {
        logic                valid;
        logic [RIDW_DEF-1:0] req_idx;
    } tag_t;

endpackage

// File: rtl/vpifo_rr_arb.sv
// vpifo_rr_arb: NREQ-way round-robin arbiter, one-hot grant, pointer moves past winner.
// Ports: clk, rst (sync high), req in, grant/winner/any out.
module vpifo_rr_arb
    import vpifo_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] winner,
    output logic            any
);

    logic [IDXW-1:0] ptr_q;

    // Scan from the pointer upward, wrapping; first requester found wins.
    always_comb begin
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any && req[(int'(ptr_q) + i) % NREQ]) begin
                any = 1'b1;
                grant[(int'(ptr_q) + i) % NREQ] = 1'b1;
                winner = IDXW'((int'(ptr_q) + i) % NREQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (any) begin
            if (int'(winner) == NREQ - 1) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= winner + IDXW'(1);
            end
        end
    end

endmodule

// File: rtl/vpifo_req_sched.sv
// vpifo_req_sched: per-tree round-robin scheduler feeding vPIFO push/pop lanes.
// Ports: i_req_* requesters (valid/ready), o_push/o_pop/o_push_data/o_tree_id lane
// strobes, i_task_fifo_full lane backpressure, i_pop_data lane results,
// o_rsp_* routed pop responses, o_occ per-tree occupancy.
// Option VPIFO_SCHED_STATS_EN adds o_stats (push/pop/blocked counters per tree).
module vpifo_req_sched
    import vpifo_sched_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int LEVEL   = LEVEL_DEF,
    parameter int PTW     = PTW_DEF,
    parameter int TIDW    = TIDW_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int POP_LAT = POP_LAT_DEF
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [NREQ-1:0]                   i_req_valid,
    output logic [NREQ-1:0]                   o_req_ready,
    input  logic [NREQ-1:0]                   i_req_op,
    input  logic [NREQ-1:0][TIDW-1:0]         i_req_tid,
    input  logic [NREQ-1:0][PTW-1:0]          i_req_data,
    output logic [LEVEL-1:0]                  o_push,
    output logic [LEVEL-1:0]                  o_pop,
    output logic [LEVEL-1:0][PTW-1:0]         o_push_data,
    output logic [LEVEL-1:0][TIDW-1:0]        o_tree_id,
    input  logic [LEVEL-1:0]                  i_task_fifo_full,
    input  logic [LEVEL-1:0][PTW-1:0]         i_pop_data,
    output logic [NREQ-1:0]                   o_rsp_valid,
    output logic [NREQ-1:0][PTW-1:0]          o_rsp_data,
    output logic [LEVEL-1:0][$clog2(DEPTH):0] o_occ
`ifdef VPIFO_SCHED_STATS_EN
    ,
    output logic [LEVEL-1:0][2:0][31:0]       o_stats
`endif
);

    localparam int OCCW = $clog2(DEPTH) + 1;
    localparam int RIDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [OCCW-1:0] OCC_MAX = OCCW'(DEPTH);

    req_t [NREQ-1:0]            req;
    logic [NREQ-1:0]            elig;
    logic [LEVEL-1:0][NREQ-1:0] lane_req;
    logic [LEVEL-1:0][NREQ-1:0] lane_gnt;
    logic [LEVEL-1:0][RIDW-1:0] lane_win;
    logic [LEVEL-1:0]           lane_any;
    logic [LEVEL-1:0]           lane_push;
    logic [LEVEL-1:0]           lane_pop;
    logic [LEVEL-1:0][RIDW-1:0] lane_idx_q;
    logic [NREQ-1:0]            rsp_valid_n;
    logic [NREQ-1:0][PTW-1:0]   rsp_data_n;
    tag_t                       tag_q [LEVEL][POP_LAT];

    always_comb begin
        for (int r = 0; r < NREQ; r++) begin
            req[r] = '{op: op_e'(i_req_op[r]),
                       tid: i_req_tid[r],
                       data: i_req_data[r]};
        end
    end

    // Occupancy bounds gate eligibility, so the counter can never over/underflow.
    always_comb begin
        elig = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (req[r].op == OP_PUSH) begin
                elig[r] = i_req_valid[r]
                        && (o_occ[req[r].tid] < OCC_MAX)
                        && !i_task_fifo_full[req[r].tid];
            end else begin
                elig[r] = i_req_valid[r]
                        && (o_occ[req[r].tid] != '0);
            end
        end
    end

    // Each requester names one tree, so it can appear in only one lane vector.
    always_comb begin
        lane_req = '0;
        for (int t = 0; t < LEVEL; t++) begin
            for (int r = 0; r < NREQ; r++) begin
                lane_req[t][r] = elig[r] && (req[r].tid == TIDW'(t));
            end
        end
    end

    for (genvar t = 0; t < LEVEL; t++) begin : g_lane
        vpifo_rr_arb #(
            .NREQ (NREQ)
        ) u_arb (
            .clk    (i_clk),
            .rst    (i_rst),
            .req    (lane_req[t]),
            .grant  (lane_gnt[t]),
            .winner (lane_win[t]),
            .any    (lane_any[t])
        );
    end

    always_comb begin
        o_req_ready = '0;
        lane_push   = '0;
        lane_pop    = '0;
        for (int t = 0; t < LEVEL; t++) begin
            o_req_ready = o_req_ready | lane_gnt[t];
            lane_push[t] = lane_any[t] && (req[lane_win[t]].op == OP_PUSH);
            lane_pop[t]  = lane_any[t] && (req[lane_win[t]].op == OP_POP);
        end
    end

    // Tail of each lane's tag pipe lines up with that lane's pop data.
    always_comb begin
        rsp_valid_n = '0;
        rsp_data_n  = '0;
        for (int t = 0; t < LEVEL; t++) begin
            if (tag_q[t][POP_LAT-1].valid) begin
                rsp_valid_n[tag_q[t][POP_LAT-1].req_idx] = 1'b1;
                rsp_data_n[tag_q[t][POP_LAT-1].req_idx]  = i_pop_data[t];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_push      <= '0;
            o_pop       <= '0;
            o_push_data <= '0;
            o_rsp_valid <= '0;
            o_rsp_data  <= '0;
            o_occ       <= '0;
            lane_idx_q  <= '0;
            for (int t = 0; t < LEVEL; t++) begin
                o_tree_id[t] <= TIDW'(t);
                for (int s = 0; s < POP_LAT; s++) begin
                    tag_q[t][s] <= '0;
                end
            end
        end else begin
            o_push      <= lane_push;
            o_pop       <= lane_pop;
            o_rsp_valid <= rsp_valid_n;
            o_rsp_data  <= rsp_data_n;
            for (int t = 0; t < LEVEL; t++) begin
                o_tree_id[t]   <= TIDW'(t);
                o_push_data[t] <= lane_push[t] ? req[lane_win[t]].data : '0;
                lane_idx_q[t]  <= lane_win[t];
                if (lane_push[t]) begin
                    o_occ[t] <= o_occ[t] + OCCW'(1);
                end else if (lane_pop[t]) begin
                    o_occ[t] <= o_occ[t] - OCCW'(1);
                end
                // Tag enters when the lane strobe is visible, not at grant.
                tag_q[t][0] <= '{valid: o_pop[t], req_idx: lane_idx_q[t]};
                for (int s = 1; s < POP_LAT; s++) begin
                    tag_q[t][s] <= tag_q[t][s-1];
                end
            end
        end
    end

`ifdef VPIFO_SCHED_STATS_EN
    logic [LEVEL-1:0]           blocked;
    logic [LEVEL-1:0][2:0][31:0] stats_q;

    // Blocked: some valid request targets the tree but was not granted.
    always_comb begin
        blocked = '0;
        for (int t = 0; t < LEVEL; t++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (i_req_valid[r] && (req[r].tid == TIDW'(t))
                    && !lane_gnt[t][r]) begin
                    blocked[t] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stats_q <= '0;
        end else begin
            for (int t = 0; t < LEVEL; t++) begin
                if (lane_push[t] && (stats_q[t][STAT_PUSH] != '1)) begin
                    stats_q[t][STAT_PUSH] <= stats_q[t][STAT_PUSH] + 32'd1;
                end
                if (lane_pop[t] && (stats_q[t][STAT_POP] != '1)) begin
                    stats_q[t][STAT_POP] <= stats_q[t][STAT_POP] + 32'd1;
                end
                if (blocked[t] && (stats_q[t][STAT_BLOCK] != '1)) begin
                    stats_q[t][STAT_BLOCK] <= stats_q[t][STAT_BLOCK] + 32'd1;
                end
            end
        end
    end

    assign o_stats = stats_q;
`endif

endmodule

// File: tb/tb_vpifo_req_sched.sv
// tb_vpifo_req_sched: directed table plus corner sequences for vpifo_req_sched.
// Inputs change just after posedge; all outputs are sampled on negedge.
module tb_vpifo_req_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  valid, ready, op, push, pop, full, rspv;
    logic [7:0]  tid, tree_id;
    logic [31:0] data, pushd, pdata, rspd;
    logic [19:0] occ;
`ifdef VPIFO_SCHED_STATS_EN
    logic [383:0] stats;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vpifo_req_sched dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_req_valid      (valid),
        .o_req_ready      (ready),
        .i_req_op         (op),
        .i_req_tid        (tid),
        .i_req_data       (data),
        .o_push           (push),
        .o_pop            (pop),
        .o_push_data      (pushd),
        .o_tree_id        (tree_id),
        .i_task_fifo_full (full),
        .i_pop_data       (pdata),
        .o_rsp_valid      (rspv),
        .o_rsp_data       (rspd),
        .o_occ            (occ)
`ifdef VPIFO_SCHED_STATS_EN
        ,
        .o_stats          (stats)
`endif
    );

    typedef struct {
        logic [3:0]  v, o;
        logic [7:0]  t;
        logic [31:0] d;
        logic [3:0]  f;
        logic [31:0] p;
        logic [3:0]  rdy, ps, pp, rs;
        logic [31:0] pd, rd;
        logic [19:0] oc;
    } vec_t;

    vec_t vt [8];

    function automatic vec_t mk(
        input logic [3:0] v, input logic [3:0] o, input logic [7:0] t,
        input logic [31:0] d, input logic [3:0] f, input logic [31:0] p,
        input logic [3:0] rdy, input logic [3:0] ps, input logic [3:0] pp,
        input logic [3:0] rs, input logic [31:0] pd, input logic [31:0] rd,
        input logic [19:0] oc);
        vec_t x;
        x.v = v; x.o = o; x.t = t; x.d = d; x.f = f; x.p = p;
        x.rdy = rdy; x.ps = ps; x.pp = pp; x.rs = rs;
        x.pd = pd; x.rd = rd; x.oc = oc;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic [3:0] v, input logic [3:0] o,
                       input logic [7:0] t, input logic [31:0] d,
                       input logic [3:0] f, input logic [31:0] p);
        valid = v; op = o; tid = t; data = d; full = f; pdata = p;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drv(4'h0, 4'h0, 8'h00, 32'h0, 4'h0, 32'h0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idle_chk(input string nm, input logic [31:0] p,
                            input logic [3:0] exp_rsp);
        drv(4'h0, 4'h0, 8'h00, 32'h0, 4'h0, p);
        @(negedge clk);
        chk({nm, " rsp"}, 32'(rspv), 32'(exp_rsp));
        nxt();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] e_rdy, e_occ, e_ps, e_pd;

        vt[0] = mk(4'h0, 4'h0, 8'h00, 32'h0, 4'h0, 32'h0,
                   4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 32'h0, 20'h0);
        vt[1] = mk(4'hF, 4'hF, 8'he4, 32'h31211101, 4'h0, 32'h0,
                   4'hF, 4'h0, 4'h0, 4'h0, 32'h0, 32'h0, 20'h0);
        vt[2] = mk(4'h0, 4'h0, 8'h00, 32'h0, 4'h0, 32'h0,
                   4'h0, 4'hF, 4'h0, 4'h0, 32'h31211101, 32'h0,
                   {5'd1, 5'd1, 5'd1, 5'd1});
        vt[3] = mk(4'h4, 4'h0, 8'h20, 32'h0, 4'h0, 32'h0,
                   4'h4, 4'h0, 4'h0, 4'h0, 32'h0, 32'h0,
                   {5'd1, 5'd1, 5'd1, 5'd1});
        vt[4] = mk(4'h0, 4'h0, 8'h00, 32'h0, 4'h0, 32'h0,
                   4'h0, 4'h0, 4'h4, 4'h0, 32'h0, 32'h0,
                   {5'd1, 5'd0, 5'd1, 5'd1});
        vt[5] = mk(4'h0, 4'h0, 8'h00, 32'h0, 4'h0, 32'h00EE0000,
                   4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 32'h0,
                   {5'd1, 5'd0, 5'd1, 5'd1});
        vt[6] = mk(4'h0, 4'h0, 8'h00, 32'h0, 4'h0, 32'h00210000,
                   4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 32'h0,
                   {5'd1, 5'd0, 5'd1, 5'd1});
        vt[7] = mk(4'h0, 4'h0, 8'h00, 32'h0, 4'h0, 32'h00EE0000,
                   4'h0, 4'h0, 4'h0, 4'h4, 32'h0, 32'h00210000,
                   {5'd1, 5'd0, 5'd1, 5'd1});

        // Parallel push to all trees, then a routed pop from tree 2.
        do_reset();
        @(negedge clk);
        chk("reset tree_id", 32'(tree_id), 32'h000000e4);
        for (int i = 0; i < 8; i++) begin
            drv(vt[i].v, vt[i].o, vt[i].t, vt[i].d, vt[i].f, vt[i].p);
            @(negedge clk);
            chk($sformatf("v%0d ready", i), 32'(ready), 32'(vt[i].rdy));
            chk($sformatf("v%0d push", i), 32'(push), 32'(vt[i].ps));
            chk($sformatf("v%0d pop", i), 32'(pop), 32'(vt[i].pp));
            chk($sformatf("v%0d rspv", i), 32'(rspv), 32'(vt[i].rs));
            chk($sformatf("v%0d pushd", i), pushd, vt[i].pd);
            chk($sformatf("v%0d rspd", i), rspd, vt[i].rd);
            chk($sformatf("v%0d occ", i), 32'(occ), 32'(vt[i].oc));
            nxt();
        end

        // All four hammer tree 0 until it is full.
        do_reset();
        for (int k = 0; k < 18; k++) begin
            drv(4'hF, 4'hF, 8'h00, 32'h43424140, 4'h0, 32'h0);
            e_rdy = (k < 16) ? (32'd1 << (k % 4)) : 32'd0;
            e_occ = (k <= 16) ? 32'(k) : 32'd16;
            e_ps  = (k >= 1 && k <= 16) ? 32'd1 : 32'd0;
            e_pd  = (e_ps != 0) ? 32'(8'h40 + (k - 1) % 4) : 32'd0;
            @(negedge clk);
            chk($sformatf("fill%0d ready", k), 32'(ready), e_rdy);
            chk($sformatf("fill%0d occ0", k), 32'(occ[4:0]), e_occ);
            chk($sformatf("fill%0d push0", k), 32'(push[0]), e_ps);
            chk($sformatf("fill%0d pushd0", k), 32'(pushd[7:0]), e_pd);
            nxt();
        end

        // Pop on empty tree 1 waits until a push lands there.
        for (int k = 0; k < 2; k++) begin
            drv(4'h1, 4'h0, 8'h01, 32'h0, 4'h0, 32'h0);
            @(negedge clk);
            chk($sformatf("empty%0d ready", k), 32'(ready), 32'h0);
            nxt();
        end
        drv(4'h9, 4'h8, 8'h41, 32'h77000000, 4'h0, 32'h0);
        @(negedge clk);
        chk("e_push ready", 32'(ready), 32'h8);
        nxt();
        drv(4'h1, 4'h0, 8'h01, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("e_pop ready", 32'(ready), 32'h1);
        chk("e_pop push", 32'(push), 32'h2);
        chk("e_pop pushd1", 32'(pushd[15:8]), 32'h77);
        chk("e_pop occ1", 32'(occ[9:5]), 32'h1);
        nxt();
        drv(4'h0, 4'h0, 8'h00, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("e_strobe pop", 32'(pop), 32'h2);
        chk("e_strobe occ1", 32'(occ[9:5]), 32'h0);
        nxt();
        idle_chk("e_wait", 32'h0, 4'h0);
        idle_chk("e_data", 32'h00007700, 4'h0);
        drv(4'h0, 4'h0, 8'h00, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("e_rsp valid", 32'(rspv), 32'h1);
        chk("e_rsp data0", 32'(rspd[7:0]), 32'h77);
        nxt();

        // Backpressure on tree 3: pop passes, push waits for full to drop.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            drv(4'h1, 4'h1, 8'h03, 32'h0, 4'h0, 32'h0);
            @(negedge clk);
            chk($sformatf("t3fill%0d ready", k), 32'(ready), 32'h1);
            nxt();
        end
        drv(4'h6, 4'h2, 8'h3C, 32'h00005500, 4'h8, 32'h0);
        @(negedge clk);
        chk("bp0 occ3", 32'(occ[19:15]), 32'h2);
        chk("bp0 ready", 32'(ready), 32'h4);
        nxt();
        drv(4'h2, 4'h2, 8'h3C, 32'h00005500, 4'h8, 32'h0);
        @(negedge clk);
        chk("bp1 ready", 32'(ready), 32'h0);
        chk("bp1 pop", 32'(pop), 32'h8);
        chk("bp1 push", 32'(push), 32'h0);
        nxt();
        drv(4'h2, 4'h2, 8'h3C, 32'h00005500, 4'h0, 32'h0);
        @(negedge clk);
        chk("bp2 ready", 32'(ready), 32'h2);
        chk("bp2 occ3", 32'(occ[19:15]), 32'h1);
        chk("bp2 push", 32'(push), 32'h0);
        nxt();
        drv(4'h0, 4'h0, 8'h00, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("bp3 push", 32'(push), 32'h8);
        chk("bp3 pushd3", 32'(pushd[31:24]), 32'h55);
        chk("bp3 occ3", 32'(occ[19:15]), 32'h2);
        nxt();

        // Reset lands one cycle after the pop strobe; response must vanish.
        drv(4'h1, 4'h0, 8'h03, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("rr0 ready", 32'(ready), 32'h1);
        nxt();
        drv(4'h0, 4'h0, 8'h00, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("rr1 pop", 32'(pop), 32'h8);
        nxt();
        rst = 1'b1;
        @(negedge clk);
        nxt();
        rst = 1'b0;
        drv(4'h0, 4'h0, 8'h00, 32'h0, 4'h0, 32'hAA000000);
        @(negedge clk);
        chk("rr3 push", 32'(push), 32'h0);
        chk("rr3 pop", 32'(pop), 32'h0);
        chk("rr3 occ", 32'(occ), 32'h0);
        chk("rr3 pushd", pushd, 32'h0);
        chk("rr3 tree_id", 32'(tree_id), 32'he4);
        chk("rr3 ready", 32'(ready), 32'h0);
        nxt();
        for (int k = 0; k < 4; k++) begin
            drv(4'h0, 4'h0, 8'h00, 32'h0, 4'h0, 32'hAA000000);
            @(negedge clk);
            chk($sformatf("rr_tail%0d rspv", k), 32'(rspv), 32'h0);
            chk($sformatf("rr_tail%0d rspd", k), rspd, 32'h0);
            nxt();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
